score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Produces the player scores and game state that the score display consumes: `rightpscore`, `leftpscore`, `gamestate`.
- Counts rally wins reported by the ball/court logic.
- Enforces an inter-point pause, during which the ball is held reset.
- Declares the winner at WIN_SCORE and holds the final score until a new game is started.

Parameters:
- WIN_SCORE, 3, points needed to win; legal range 1..3 (fits the 2-bit score outputs).
- PAUSE_CYCLES, 50000000, clock cycles the ball is held between points (0.5 s at 100 MHz); minimum 1.
- RESTART_CYCLES, 200000000, game-over hold before auto-restart (used only with AUTO_RESTART_EN).
- CNT_W, 28, pause/restart counter width; must hold max(PAUSE_CYCLES, RESTART_CYCLES).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  synchronous, debounced level; rising edge starts a game
- left_miss  input  1  level from ball logic; rising edge = left player lost the rally (right scores)
- right_miss  input  1  level; rising edge = right player lost the rally (left scores)
- rightpscore  output  2  right player score, 0..WIN_SCORE
- leftpscore  output  2  left player score, 0..WIN_SCORE
- gamestate  output  1  1 = game in progress (PLAY/PAUSE); 0 = IDLE or GAME_OVER
- ball_reset  output  1  1 holds the ball at the serve position
- serve_right  output  1  1 = right player serves next rally

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - scores 0, gamestate 0, ball_reset 1, serve_right 0, state IDLE, counter 0.
  - Edge-detect history registers reset to 1, so an input held high through reset does not fire.
- Edge detection:
  - `start`, `left_miss` and `right_miss` are each registered once.
  - An event is input & ~input_d. Event latency is 1 cycle after the input rises.
- States: IDLE, PLAY, PAUSE, GAME_OVER.
- IDLE:
  - Outputs: ball_reset=1, gamestate=0, scores hold their last values.
  - On start event: scores cleared to 0, serve_right=0, go to PAUSE with counter loaded to PAUSE_CYCLES-1.
- PAUSE:
  - Outputs: ball_reset=1, gamestate=1.
  - Counter decrements each cycle. At 0 go to PLAY, so ball_reset deasserts PAUSE_CYCLES cycles after PAUSE entry.
  - Miss events are ignored.
- PLAY:
  - Outputs: ball_reset=0, gamestate=1.
  - right_miss event: leftpscore += 1, serve_right=0 (point winner serves).
  - left_miss event: rightpscore += 1, serve_right=1.
  - Both events in the same cycle: rally void. No score change, go to PAUSE, serve_right unchanged.
  - After a single event: if the new score equals WIN_SCORE go to GAME_OVER, else go to PAUSE with counter reloaded.
  - Score update and state change occur on the same clock edge.
  - Scores never exceed WIN_SCORE; there is no wrap-around.
- GAME_OVER:
  - Outputs: gamestate=0, ball_reset=1.
  - Scores frozen, so the display shows the winner (score == WIN_SCORE with gamestate 0).
  - start event → same as the IDLE start path (new game).
  - Miss events ignored.
- start events in PLAY/PAUSE are ignored; there is no mid-game restart.
- Reset asserted mid-rally or mid-pause: immediate return to reset values; no partial score is retained.

Optional Feature:
- Macro: SCORE_KEEPER_AUTO_RESTART_EN.
- Defined:
  - GAME_OVER loads the counter with RESTART_CYCLES-1 on entry.
  - At 0, go to IDLE with scores cleared to 0.
  - A start event before expiry still starts a new game immediately.
- Undefined: GAME_OVER persists until a start event. RESTART_CYCLES is unused and the counter is not loaded.

Decomposition:
- Package score_pkg:
  - state enum (IDLE, PLAY, PAUSE, GAME_OVER) in 2-bit encoding.
  - SCORE_W=2.
  - Default WIN_SCORE/PAUSE_CYCLES constants, shared with the display and ball logic.
- Sub-module rise_detect:
  - Parameterised width; one register per bit; reset value 1.
  - Instantiated once, 3 bits wide, for start/left_miss/right_miss.
- The down-counter stays inline in score_keeper.

Test Plan:
- Reset with start held high, then release reset → no game starts. Drop start, raise it → gamestate=1 next-next cycle; ball_reset=1 for exactly PAUSE_CYCLES (bench override 4) cycles, then 0.
- In PLAY, pulse right_miss → leftpscore 0→1, serve_right=0, PAUSE entered. Pulse left_miss during PAUSE → ignored, rightpscore stays 0.
- Both misses rise on the same cycle in PLAY → scores unchanged, PAUSE re-entered, serve_right unchanged.
- Left reaches 3 (WIN_SCORE=3) → gamestate=0, ball_reset=1, scores frozen at 3/x. Further misses change nothing. A start event clears scores to 0/0.
- Assert reset in the middle of PLAY with score 2/1 → outputs immediately 0/0, gamestate=0, ball_reset=1, state IDLE.
- With SCORE_KEEPER_AUTO_RESTART_EN and RESTART_CYCLES=6: game over → IDLE with scores 0/0 exactly 6 cycles after GAME_OVER entry. Without the macro: still GAME_OVER after 100 cycles.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared score/game types and default timing used by the scorer, display and ball logic.
package score_pkg;

  localparam int SCORE_W          = 2;
  localparam int DEF_WIN_SCORE    = 3;
  localparam int DEF_PAUSE_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    PAUSE     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Rally events in, scores and game status out; master drives the events, slave is the scorer.
interface score_keeper_if;
  import score_pkg::*;

  logic               start;
  logic               left_miss;
  logic               right_miss;
  logic [SCORE_W-1:0] rightpscore;
  logic [SCORE_W-1:0] leftpscore;
  logic               gamestate;
  logic               ball_reset;
  logic               serve_right;

  modport master (
    output start, left_miss, right_miss,
    input  rightpscore, leftpscore, gamestate, ball_reset, serve_right
  );

  modport slave (
    input  start, left_miss, right_miss,
    output rightpscore, leftpscore, gamestate, ball_reset, serve_right
  );

endinterface

// File: rtl/score_keeper_rise_detect.sv
// Per-bit rising-edge detector; history resets to 1 so a level held through reset never fires.
module rise_detect #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] din_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_d <= '1;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/score_keeper.sv
// Pong scorer: counts rally wins, times the inter-point pause, holds the final score at game over.
// Optional SCORE_KEEPER_AUTO_RESTART_EN returns GAME_OVER to IDLE after RESTART_CYCLES.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int PAUSE_CYCLES   = DEF_PAUSE_CYCLES,
  parameter int RESTART_CYCLES = 200_000_000,
  parameter int CNT_W          = 28
) (
  input  logic         clock,
  input  logic         reset,
  score_keeper_if.slave sk
);

  if (WIN_SCORE < 1 || WIN_SCORE > 3 || PAUSE_CYCLES < 1 || RESTART_CYCLES < 1) begin : g_bad_params
    $error("score_keeper: illegal parameter value");
  end

  localparam logic [SCORE_W-1:0] WIN_SC     = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0]   RESTART_LOAD = CNT_W'(RESTART_CYCLES - 1);
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] lscore;
  logic [SCORE_W-1:0] rscore;
  logic               serve;
  logic [2:0]         ev;
  logic               ev_start;
  logic               ev_lmiss;
  logic               ev_rmiss;
  logic [SCORE_W-1:0] lnext;
  logic [SCORE_W-1:0] rnext;

  rise_detect #(.W(3)) u_rise (
    .clock (clock),
    .reset (reset),
    .din   ({sk.start, sk.left_miss, sk.right_miss}),
    .rise  (ev)
  );

  assign ev_start = ev[2];
  assign ev_lmiss = ev[1];
  assign ev_rmiss = ev[0];
  // Scores are strictly below WIN_SCORE while in PLAY, so these never wrap.
  assign lnext    = lscore + 2'd1;
  assign rnext    = rscore + 2'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lscore <= '0;
      rscore <= '0;
      serve  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_start) begin
            lscore <= '0;
            rscore <= '0;
            serve  <= 1'b0;
            cnt    <= PAUSE_LOAD;
            state  <= PAUSE;
          end
        end
        PAUSE: begin
          if (cnt == '0) begin
            state <= PLAY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PLAY: begin
          if (ev_lmiss && ev_rmiss) begin
            cnt   <= PAUSE_LOAD;
            state <= PAUSE;
          end else if (ev_rmiss || ev_lmiss) begin
            if (ev_rmiss) begin
              lscore <= lnext;
              serve  <= 1'b0;
            end else begin
              rscore <= rnext;
              serve  <= 1'b1;
            end
            if ((ev_rmiss && lnext == WIN_SC) || (ev_lmiss && rnext == WIN_SC)) begin
              state <= GAME_OVER;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
              cnt   <= RESTART_LOAD;
`endif
            end else begin
              cnt   <= PAUSE_LOAD;
              state <= PAUSE;
            end
          end
        end
        GAME_OVER: begin
          if (ev_start) begin
            lscore <= '0;
            rscore <= '0;
            serve  <= 1'b0;
            cnt    <= PAUSE_LOAD;
            state  <= PAUSE;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
          end else if (cnt == '0) begin
            lscore <= '0;
            rscore <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sk.leftpscore  = lscore;
  assign sk.rightpscore = rscore;
  assign sk.serve_right = serve;
  assign sk.gamestate   = (state == PLAY) || (state == PAUSE);
  assign sk.ball_reset  = (state != PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed check of score_keeper against a timestamp-based game model.
module tb_score_keeper;

  localparam int WIN     = 3;
  localparam int PAUSE   = 4;
  localparam int RESTART = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  score_keeper_if sk_if ();

  score_keeper #(
    .WIN_SCORE      (WIN),
    .PAUSE_CYCLES   (PAUSE),
    .RESTART_CYCLES (RESTART),
    .CNT_W          (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sk    (sk_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // Game model: the ball is live once the edge count passes live_at.
  int n, live_at, over_at, ls, rs;
  bit game_on, over, srv, ps, pl, pr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    ls = 0; rs = 0; srv = 0; game_on = 0; over = 0;
    ps = 1; pl = 1; pr = 1;
    live_at = 0; over_at = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit r);
    bit es, el, er;
    n++;
    es = s & ~ps; el = l & ~pl; er = r & ~pr;
    ps = s; pl = l; pr = r;
    if (!game_on) begin
      if (es) begin
        ls = 0; rs = 0; srv = 0; game_on = 1; over = 0; live_at = n + PAUSE;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
      end else if (over && n >= over_at + RESTART) begin
        over = 0; ls = 0; rs = 0;
`endif
      end
    end else if (n > live_at) begin
      if (el && er) begin
        live_at = n + PAUSE;
      end else if (er || el) begin
        if (er) begin ls++; srv = 0; end
        else    begin rs++; srv = 1; end
        if (ls == WIN || rs == WIN) begin
          game_on = 0; over = 1; over_at = n;
        end else begin
          live_at = n + PAUSE;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("leftpscore",  32'(sk_if.leftpscore),  32'(ls));
    chk("rightpscore", 32'(sk_if.rightpscore), 32'(rs));
    chk("gamestate",   32'(sk_if.gamestate),   32'(game_on));
    chk("ball_reset",  32'(sk_if.ball_reset),  32'(!(game_on && n >= live_at)));
    chk("serve_right", 32'(sk_if.serve_right), 32'(srv));
  endtask

  // Called at a negedge: drive, clock once, compare at the following negedge.
  task automatic cyc(input bit s, input bit l, input bit r);
    sk_if.start = s; sk_if.left_miss = l; sk_if.right_miss = r;
    @(posedge clock);
    model_step(s, l, r);
    @(negedge clock);
    compare_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(sk_if.start, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_gamestate", 32'(sk_if.gamestate), 32'd0);
    chk("rst_ball_reset", 32'(sk_if.ball_reset), 32'd1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n = 0;
    model_reset();
    sk_if.start = 1'b1; sk_if.left_miss = 1'b0; sk_if.right_miss = 1'b0;
    #12;
    compare_all();
    @(negedge clock);
    reset = 1'b1;

    // start held high through reset must not start a game
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    chk("no_start_thru_rst", 32'(sk_if.gamestate), 32'd0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("start_gamestate", 32'(sk_if.gamestate), 32'd1);
    for (int i = 1; i < PAUSE; i++) begin
      cyc(1, 0, 0);
      chk("pause_hold", 32'(sk_if.ball_reset), 32'd1);
    end
    cyc(1, 0, 0);
    chk("pause_release", 32'(sk_if.ball_reset), 32'd0);

    cyc(1, 0, 1);
    chk("first_point", 32'(sk_if.leftpscore), 32'd1);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("miss_in_pause", 32'(sk_if.rightpscore), 32'd0);
    run(4);
    cyc(1, 1, 1);
    chk("void_rally_l", 32'(sk_if.leftpscore), 32'd1);
    chk("void_rally_br", 32'(sk_if.ball_reset), 32'd1);
    run(5);
    cyc(1, 0, 1); run(5);
    cyc(1, 0, 1);
    chk("win_score", 32'(sk_if.leftpscore), 32'd3);
    chk("win_gamestate", 32'(sk_if.gamestate), 32'd0);
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 1);
    run(100);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    chk("auto_restart", 32'(sk_if.leftpscore), 32'd0);
`else
    chk("over_persists", 32'(sk_if.leftpscore), 32'd3);
`endif
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("new_game", 32'({sk_if.leftpscore, sk_if.rightpscore}), 32'd0);

    // reach 2/1 then reset mid-rally
    run(5);
    cyc(1, 0, 1); run(5);
    cyc(1, 0, 1); run(5);
    cyc(1, 1, 0); run(6);
    mid_reset();
    @(negedge clock);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
        @(negedge clock);
      end else begin
        cyc($urandom_range(0, 15) != 0 ? sk_if.start : ~sk_if.start,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
